// File: rtl/stack_sequencer.sv
// Command sequencer for an external LIFO stack: turns PUSH/POP/ALU commands into
// push/pop strobe sequences, evaluates the ALU ops and tracks stack depth locally.
module stack_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             push,
  output logic             pop,
  output logic [WIDTH-1:0] stack_in,
  input  logic [WIDTH-1:0] stack_out,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             error,
  output logic [N:0]       depth
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERR   = 3'd1,
    POP1  = 3'd2,
    POP2  = 3'd3,
    LATCH = 3'd4,
    PUSHR = 3'd5,
    OUT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_PUSH = 3'b000,
    OP_POP  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_NOT  = 3'b101,
    OP_DUP  = 3'b110,
    OP_NOP  = 3'b111
  } op_t;

  localparam logic [N:0] FULL_DEPTH = (N+1)'(DEPTH);

  state_t           state_reg, state_next;
  op_t              op_reg, op_next;
  op_t              cmd_op_t;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] stack_in_next, result_next;
  logic             push_next, pop_next, result_valid_next, error_next, cmd_ready_next;
  logic [N:0]       depth_next;
  logic [N:0]       need;
  logic             accept;
  logic             grows;
  logic             is_binary;

  assign cmd_op_t = op_t'(cmd_op);
  assign accept   = cmd_valid && cmd_ready && (state_reg == IDLE);
  assign grows    = (cmd_op_t == OP_PUSH) || (cmd_op_t == OP_DUP);
  assign is_binary = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_AND);

  // Number of entries the incoming command must find on the stack.
  always_comb begin
    need = '0;
    case (cmd_op_t)
      OP_POP, OP_NOT, OP_DUP: need = (N+1)'(1);
      OP_ADD, OP_SUB, OP_AND: need = (N+1)'(2);
      default:                need = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_NOP;
      opa_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      opa_reg   <= opa_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    opa_next      = opa_reg;
    stack_in_next = stack_in;
    result_next   = result;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next = cmd_op_t;
          if ((depth < need) || (grows && (depth == FULL_DEPTH))) begin
            state_next = ERR;
          end else begin
            case (cmd_op_t)
              OP_PUSH: begin
                state_next    = PUSHR;
                stack_in_next = cmd_imm;
              end
              // No strobe this cycle, so stack_out shows TOS next cycle.
              OP_DUP:  state_next = LATCH;
              OP_NOP:  state_next = IDLE;
              default: state_next = POP1;
            endcase
          end
        end
      end
      ERR:   state_next = IDLE;
      POP1:  state_next = is_binary ? POP2 : LATCH;
      POP2: begin
        opa_next   = stack_out;
        state_next = LATCH;
      end
      // stack_out now holds A (unary/POP), B (binary) or TOS (DUP).
      LATCH: begin
        state_next = PUSHR;
        case (op_reg)
          OP_POP: begin
            result_next = stack_out;
            state_next  = OUT;
          end
          OP_ADD:  stack_in_next = stack_out + opa_reg;
          OP_SUB:  stack_in_next = stack_out - opa_reg;
          OP_AND:  stack_in_next = stack_out & opa_reg;
          OP_NOT:  stack_in_next = ~stack_out;
          OP_DUP:  stack_in_next = stack_out;
          default: state_next = IDLE;
        endcase
      end
      PUSHR:   state_next = IDLE;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and flags are registered from the next state so they line up with it.
  always_comb begin
    push_next         = (state_next == PUSHR);
    pop_next          = (state_next == POP1) || (state_next == POP2);
    result_valid_next = (state_next == OUT);
    error_next        = (state_next == ERR);
    cmd_ready_next    = (state_next == IDLE);
    depth_next        = depth;
    if (push_next) begin
      depth_next = depth + (N+1)'(1);
    end else if (pop_next) begin
      depth_next = depth - (N+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push         <= 1'b0;
      pop          <= 1'b0;
      stack_in     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      cmd_ready    <= 1'b0;
      depth        <= '0;
    end else begin
      push         <= push_next;
      pop          <= pop_next;
      stack_in     <= stack_in_next;
      result       <= result_next;
      result_valid <= result_valid_next;
      error        <= error_next;
      cmd_ready    <= cmd_ready_next;
      depth        <= depth_next;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer: a behavioural stack drives stack_out and a
// queue-based reference model predicts latency, strobes, results, errors and depth.
module tb_stack_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int N     = 2;

  localparam logic [2:0] C_PUSH = 3'b000, C_POP = 3'b001, C_ADD = 3'b010, C_SUB = 3'b011;
  localparam logic [2:0] C_AND  = 3'b100, C_NOT = 3'b101, C_DUP = 3'b110, C_NOP = 3'b111;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'b111;
  logic [WIDTH-1:0] cmd_imm = '0;
  logic             push, pop;
  logic [WIDTH-1:0] stack_in, stack_out, result;
  logic             result_valid, error;
  logic [N:0]       depth;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] last_res;
  logic [7:0] ref_q[$];

  always #5 clk = ~clk;

  stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N(N)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .push(push), .pop(pop),
    .stack_in(stack_in), .stack_out(stack_out), .result(result),
    .result_valid(result_valid), .error(error), .depth(depth)
  );

  // Attached stack: pop shows the popped value next cycle, idle shows the top.
  logic [7:0] smem [0:DEPTH-1];
  int         sp;
  logic [7:0] sout;
  assign stack_out = sout;

  always @(posedge clk) begin
    if (reset) begin
      sp   <= 0;
      sout <= '0;
    end else if (push) begin
      if (sp < DEPTH) smem[sp] <= stack_in;
      sp   <= sp + 1;
      sout <= stack_in;
    end else if (pop) begin
      sout <= (sp > 0) ? smem[sp-1] : 8'h00;
      sp   <= sp - 1;
    end else begin
      sout <= (sp > 0) ? smem[sp-1] : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic string op_name(input logic [2:0] op);
    case (op)
      C_PUSH: return "PUSH";
      C_POP:  return "POP";
      C_ADD:  return "ADD";
      C_SUB:  return "SUB";
      C_AND:  return "AND";
      C_NOT:  return "NOT";
      C_DUP:  return "DUP";
      default: return "NOP";
    endcase
  endfunction

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] imm);
    int k, exp_lat, exp_push, exp_pop;
    bit exp_err, exp_rv;
    logic [7:0] exp_res, a, b;
    int lat, n_push, n_pop, n_err, n_rv, err_cyc, rv_cyc;
    bit both, ready_seen;
    logic [7:0] got_res;

    // Reference model on a plain queue.
    k = (op == C_POP || op == C_NOT || op == C_DUP) ? 1 :
        (op == C_ADD || op == C_SUB || op == C_AND) ? 2 : 0;
    exp_err = 0; exp_rv = 0; exp_res = 8'h00; exp_push = 0; exp_pop = 0; exp_lat = 1;
    if (ref_q.size() < k || ((op == C_PUSH || op == C_DUP) && ref_q.size() == DEPTH)) begin
      exp_err = 1; exp_lat = 2;
    end else begin
      case (op)
        C_PUSH: begin ref_q.push_back(imm); exp_push = 1; exp_lat = 2; end
        C_POP: begin
          exp_res = ref_q.pop_back(); exp_rv = 1; exp_pop = 1; exp_lat = 4;
        end
        C_ADD, C_SUB, C_AND: begin
          a = ref_q.pop_back();
          b = ref_q.pop_back();
          if (op == C_ADD) ref_q.push_back(8'((int'(b) + int'(a)) % 256));
          else if (op == C_SUB) ref_q.push_back(8'((int'(b) - int'(a) + 256) % 256));
          else ref_q.push_back(b & a);
          exp_pop = 2; exp_push = 1; exp_lat = 5;
        end
        C_NOT: begin
          a = ref_q.pop_back();
          ref_q.push_back(8'(255 - int'(a)));
          exp_pop = 1; exp_push = 1; exp_lat = 4;
        end
        C_DUP: begin
          a = ref_q[ref_q.size()-1];
          ref_q.push_back(a);
          exp_push = 1; exp_lat = 3;
        end
        default: exp_lat = 1;
      endcase
    end

    ready_seen = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (cmd_ready) begin ready_seen = 1; break; end
    end
    check("ready_wait", 32'(ready_seen), 32'd1);
    if (!ready_seen) return;

    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    lat = 0; n_push = 0; n_pop = 0; n_err = 0; n_rv = 0;
    err_cyc = 0; rv_cyc = 0; both = 0; got_res = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (push) n_push++;
      if (pop) n_pop++;
      if (push && pop) both = 1;
      if (error) begin n_err++; err_cyc = c; end
      if (result_valid) begin n_rv++; rv_cyc = c; got_res = result; end
      if (cmd_ready) begin lat = c; break; end
    end
    last_res = got_res;

    check("latency", 32'(lat), 32'(exp_lat));
    check("error_cnt", 32'(n_err), 32'(exp_err));
    check("push_cnt", 32'(n_push), 32'(exp_push));
    check("pop_cnt", 32'(n_pop), 32'(exp_pop));
    check("rv_cnt", 32'(n_rv), 32'(exp_rv));
    check("push_pop_excl", 32'(both), 32'd0);
    check("depth", 32'(depth), 32'(ref_q.size()));
    if (exp_err) check("error_cycle", 32'(err_cyc), 32'd1);
    if (exp_rv) begin
      check("rv_cycle", 32'(rv_cyc), 32'd3);
      check("result", 32'(got_res), 32'(exp_res));
    end
    $display("cmd %-4s imm=%02h err=%0d rv=%0d res=%02h lat=%0d depth=%0d",
             op_name(op), imm, n_err, n_rv, got_res, lat, depth);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_strobes", {30'd0, push, pop}, 32'd0);
    check("rst_flags", {30'd0, result_valid, error}, 32'd0);
    check("rst_data", {16'd0, stack_in, result}, 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    reset = 1'b0;
    ref_q.delete();
    @(negedge clk);
    check("rst_ready_after", 32'(cmd_ready), 32'd1);
    $display("reset done");
  endtask

  task automatic reset_mid_add();
    int pushes;
    do_cmd(C_PUSH, 8'd1);
    do_cmd(C_PUSH, 8'd2);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_ADD; cmd_imm = 8'h00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);           // POP1
    check("mid_pop1", 32'(pop), 32'd1);
    @(negedge clk);           // POP2: raise reset here
    reset = 1'b1;
    pushes = 0;
    @(negedge clk);
    if (push) pushes++;
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    ref_q.delete();
    @(negedge clk);
    check("mid_ready_after", 32'(cmd_ready), 32'd1);
    check("mid_depth", 32'(depth), 32'd0);
    for (int c = 0; c < 5; c++) begin
      if (push) pushes++;
      @(negedge clk);
    end
    check("mid_no_push", 32'(pushes), 32'd0);
    $display("reset during ADD: pushes after reset=%0d depth=%0d", pushes, depth);
    do_cmd(C_POP, 8'h00);
  endtask

  initial begin
    do_reset();
    do_cmd(C_PUSH, 8'd5); do_cmd(C_PUSH, 8'd3); do_cmd(C_SUB, 8'h00); do_cmd(C_POP, 8'h00);
    check("sub_5_3", 32'(last_res), 32'h02);
    do_cmd(C_PUSH, 8'h80); do_cmd(C_PUSH, 8'h90); do_cmd(C_ADD, 8'h00); do_cmd(C_POP, 8'h00);
    check("add_wrap", 32'(last_res), 32'h10);
    do_cmd(C_PUSH, 8'h0F); do_cmd(C_NOT, 8'h00); do_cmd(C_POP, 8'h00);
    check("not_0f", 32'(last_res), 32'hF0);

    do_reset();
    do_cmd(C_ADD, 8'h00);
    do_cmd(C_PUSH, 8'h11); do_cmd(C_PUSH, 8'h22); do_cmd(C_PUSH, 8'h33); do_cmd(C_PUSH, 8'h44);
    check("full_depth", 32'(depth), 32'd4);
    do_cmd(C_PUSH, 8'h55); do_cmd(C_DUP, 8'h00);
    do_cmd(C_POP, 8'h00);
    check("pop_after_full", 32'(last_res), 32'h44);

    do_reset();
    do_cmd(C_PUSH, 8'd7); do_cmd(C_DUP, 8'h00); do_cmd(C_ADD, 8'h00); do_cmd(C_POP, 8'h00);
    check("dup_add", 32'(last_res), 32'd14);
    do_cmd(C_NOP, 8'h00);

    reset_mid_add();

    for (int i = 0; i < 400; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Command-driven controller for the `Stack` block in the stack-machine datapath. It accepts one operation at a time over a valid/ready handshake and drives the stack's `push`/`pop`/`stack_in` strobes. It reads operands back from `stack_out`, evaluates ADD/SUB/AND/NOT/DUP in its own ALU and pushes results back. It tracks stack depth itself and reports underflow and overflow without touching the stack.

## Interface
- `WIDTH`, 8: data width; matches the stack.
- `DEPTH`, 256: stack capacity in entries.
- `N`, 8: stack index width; `depth` output is N+1 bits so that DEPTH itself is representable.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high. Also routed to the attached stack.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  3  000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 DUP, 111 NOP.
- `cmd_imm`  in  WIDTH  immediate for PUSH.
- `push`  out  1  stack push strobe.
- `pop`  out  1  stack pop strobe.
- `stack_in`  out  WIDTH  data to stack.
- `stack_out`  in  WIDTH  stack read data.
- `result`  out  WIDTH  value removed by POP.
- `result_valid`  out  1  one-cycle pulse; `result` is valid.
- `error`  out  1  one-cycle pulse on underflow or overflow.
- `depth`  out  N+1  current entry count.

## Operation
- Stack read contract:
  - A pop strobe in cycle t makes the popped value appear on `stack_out` in t+1.
  - A cycle with neither strobe makes the current top appear on `stack_out` in t+1.
  - A push strobe in cycle t writes `stack_in` and increments the stack's internal pointer.
- FSM states: IDLE, ERR, POP1, POP2, LATCH, PUSHR, OUT.
- A command is accepted when `cmd_valid & cmd_ready`. `cmd_ready` = 1 only in IDLE. `cmd_op` and `cmd_imm` are captured at acceptance.
- Operand requirement k: POP 1, ADD 2, SUB 2, AND 2, NOT 1, DUP 1, PUSH 0.
- Underflow: `depth < k`. Overflow: PUSH or DUP with `depth == DEPTH`. On either, go to ERR; no strobe is issued and the stack is untouched.
- Sequences (A = top, B = next):
  - PUSH: IDLE → PUSHR (`push`=1, `stack_in`=imm) → IDLE.
  - POP: IDLE → POP1 (`pop`) → LATCH (capture A) → OUT (`result`=A, `result_valid`=1) → IDLE.
  - ADD/SUB/AND: IDLE → POP1 (`pop`) → POP2 (`pop`, capture A) → LATCH (capture B) → PUSHR (push B op A) → IDLE.
  - NOT: IDLE → POP1 → LATCH (capture A) → PUSHR (push ~A) → IDLE.
  - DUP: IDLE → LATCH (capture TOS; accept cycle had no strobe) → PUSHR (push TOS) → IDLE. Net depth +1.
  - NOP: consumed, stays in IDLE.
- ERR: `error`=1 for one cycle, then IDLE.
- Arithmetic: ADD = B+A, SUB = B−A, both modulo 2^WIDTH with carry/borrow discarded. AND bitwise; NOT bitwise invert.
- `depth` updates on every strobe: +1 for push, −1 for pop. It never wraps because error checks make wrap impossible.
- `push` and `pop` are never high in the same cycle. Neither is high outside the states listed above.

## Timing
- Reset (cycle after `reset` sampled high): state IDLE; `push`, `pop`, `result_valid`, `error` = 0; `stack_in`, `result` = 0; `depth` = 0; `cmd_ready` = 0 during the reset cycle, 1 from the first cycle after reset deasserts.
- Reset mid-sequence aborts the command. No further strobes are issued. The stack is reset by the same line.
- Latency from accept cycle T to return to IDLE with `cmd_ready`=1:
  - PUSH: T+2.
  - POP: T+4, with `result_valid` at T+3.
  - Binary ops: T+5.
  - NOT: T+4.
  - DUP: T+3.
  - Error: T+2, with `error` at T+1.
  - NOP: T+1.
- All outputs are registered; no combinational path from inputs to outputs except none (`cmd_ready` decodes state).
- The cycle after any PUSHR is IDLE with no strobe. This guarantees `stack_out` = TOS for a following DUP.

## Test plan
- Reset, then PUSH 5, PUSH 3, SUB, POP → `result_valid` pulse with `result`=2; `depth` sequence 1, 2, 1, 0; `error` never asserted.
- PUSH 0x80, PUSH 0x90, ADD, POP → `result`=0x10 (wrap); PUSH 0x0F, NOT, POP → `result`=0xF0.
- Reset, then ADD → `error` pulse at T+1; no `push`/`pop` strobes; `depth`=0; `cmd_ready` back at T+2.
- With DEPTH=4, N=2: PUSH ×4 succeeds (`depth`=4). 5th PUSH → `error`; DUP → `error`; `depth` stays 4. POP → `result` = 4th immediate.
- PUSH 7, DUP, ADD, POP → `result`=14; verify DUP takes exactly 3 cycles to IDLE.
- PUSH 1, PUSH 2, ADD with `reset` asserted in the POP2 cycle → no `push` strobe afterwards; `depth`=0; `cmd_ready`=1 after reset deasserts; a subsequent POP → `error`.
